seg_tick_counter: RTL and testbench
===================================

Name: seg_tick_counter

Overview:
- Consumer of the periodic one-cycle tick pulse produced by the 0.5 s timer (its add_flag output).
- Runs a start/stop/clear controlled hex digit counter advanced by that tick.
- Drives a static multi-digit seven-segment display: every digit shows the same value, with no scanning.
- Sits between the timer and the board's segment/select pins in the static-seg design.

Parameters:
- DIG_NUM, 6: number of static digits; width of seg_sel.
- MAX_VAL, 4'd15: highest count value; the counter runs 0..MAX_VAL. Legal range 1..15.
- SEG_ACTIVE_LOW, 1: 1 = common-anode pins (segment/select driven low to light); 0 = all output polarities inverted.

Ports:
- sys_clk, input, 1: system clock.
- sys_rst, input, 1: synchronous, active-high reset.
- tick_in, input, 1: one-cycle advance pulse from the timer.
- start, input, 1: one-cycle pulse; start or resume counting.
- stop, input, 1: one-cycle pulse; pause counting.
- clr, input, 1: one-cycle pulse; return to idle with count 0.
- dir, input, 1: 1 = count up, 0 = count down. Sampled on each tick.
- seg_sel, output, DIG_NUM: digit enables (all digits enabled together).
- seg_led, output, 8: segments {dp,g,f,e,d,c,b,a}.
- wrap_pulse, output, 1: one-cycle pulse when the count wraps.
- running, output, 1: high while in RUN.

Behaviour:
- Clock and reset: single clock, sys_clk. Reset is sys_rst, synchronous, active-high. All registers update only on the rising edge of sys_clk.
- Reset values:
  - state = IDLE, count = 0, running = 0, wrap_pulse = 0.
  - seg_sel = all digits disabled (6'h3F when active-low).
  - seg_led = all segments off (8'hFF when active-low).
- States: IDLE, RUN, PAUSE.
  - IDLE -start-> RUN.
  - RUN -stop-> PAUSE.
  - PAUSE -start-> RUN.
  - Any state -clr-> IDLE, with count <= 0.
  - Input priority: clr > stop > start.
  - start in RUN and stop in IDLE or PAUSE are ignored.
- Counting: happens only when the current (registered) state is RUN and tick_in = 1.
  - Up: count+1; MAX_VAL -> 0 wraps.
  - Down: count-1; 0 -> MAX_VAL wraps.
  - count is 4 bits; arithmetic is modulo MAX_VAL+1, never modulo 16 unless MAX_VAL = 15.
- wrap_pulse: asserted for exactly the cycle after the wrapping tick, in the same clock edge that loads the wrapped count.
- Same-cycle events:
  - tick_in with stop while in RUN: the tick is applied, then the state goes to PAUSE.
  - tick_in with clr: clr wins; count = 0 and no wrap_pulse.
  - tick_in with start while in IDLE or PAUSE: no count change.
- running: registered; equals (state == RUN). Follows the state change by 0 cycles, i.e. it is loaded on the same edge as the state.
- Display:
  - seg_sel is all enabled from the first edge after reset release, in every state.
  - seg_led is a registered decode of count, so it lags count by 1 cycle (tick_in to new seg_led = 2 edges).
  - Active-low decode 0..F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E. dp is always off.
  - SEG_ACTIVE_LOW = 0 inverts both seg_led and seg_sel.
- Reset mid-operation: sys_rst overrides everything the same edge; there is no partial update.

Optional Feature:
- Macro: SEG_BLINK_EN.
- Defined:
  - A blink register toggles on each tick_in while in PAUSE.
  - While blink = 1, seg_led shows all segments off. seg_sel is unchanged.
  - blink is cleared on entry to RUN or IDLE and on reset.
- Undefined: PAUSE shows the held count steadily; no blink register exists.

Test Plan:
- Reset release, then start, then 3 ticks with dir=1:
  - count = 3, seg_led = 8'hB0 two cycles after the 3rd tick.
  - running = 1, seg_sel = 6'h00.
- From count 15 in RUN, dir=1, one tick:
  - count = 0, wrap_pulse high for exactly 1 cycle, seg_led = 8'hC0.
  - Repeat with MAX_VAL=9 from count 9: same result.
- From count 0 in RUN, dir=0, one tick: count = 15, wrap_pulse = 1 for 1 cycle, seg_led = 8'h8E.
- tick_in and stop in the same cycle at count 4: count = 5, state PAUSE, running = 0. Further ticks leave count at 5.
- tick_in and clr in the same cycle at count 7 in RUN: count = 0, state IDLE, wrap_pulse = 0. start in the same cycle as clr is ignored.
- SEG_BLINK_EN defined, PAUSE at count 2, 4 ticks:
  - seg_led alternates FF, A4, FF, A4.
  - start then shows A4 steadily.
  - sys_rst asserted mid-run forces all reset values on the next edge.

Source files
------------

// File: rtl/seg_tick_counter.sv
// seg_tick_counter: start/stop/clr hex counter advanced by tick_in, shown on every static seven-segment digit.
// Optional SEG_BLINK_EN: while paused, the display blanks on alternate ticks.
module seg_tick_counter #(
   parameter int         DIG_NUM        = 6,
   parameter logic [3:0] MAX_VAL        = 4'd15,
   parameter bit         SEG_ACTIVE_LOW = 1'b1
) (
   input  logic               sys_clk,
   input  logic               sys_rst,
   input  logic               tick_in,
   input  logic               start,
   input  logic               stop,
   input  logic               clr,
   input  logic               dir,
   output logic [DIG_NUM-1:0] seg_sel,
   output logic [7:0]         seg_led,
   output logic               wrap_pulse,
   output logic               running
);
   typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
   localparam logic [7:0] LUT [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                       8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
   localparam logic [7:0]         SEG_OFF = {8{SEG_ACTIVE_LOW}};
   localparam logic [DIG_NUM-1:0] SEL_OFF = {DIG_NUM{SEG_ACTIVE_LOW}};
   state_t     state, state_nxt;
   logic [3:0] count, count_nxt;
   logic       step, at_edge, wrap_nxt;
   logic [7:0] seg_dec, shown;
   always_comb begin
      state_nxt = state;
      if (clr) state_nxt = IDLE;
      else if (stop && state == RUN) state_nxt = PAUSE;
      else if (start && state != RUN) state_nxt = RUN;
   end
   // wrap points are MAX_VAL going up and 0 going down, so the range is 0..MAX_VAL
   assign step      = state == RUN && tick_in && !clr;
   assign at_edge   = dir ? count == MAX_VAL : count == 4'd0;
   assign wrap_nxt  = step && at_edge;
   assign count_nxt = clr ? 4'd0 : !step ? count : at_edge ? (dir ? 4'd0 : MAX_VAL) : dir ? count + 4'd1 : count - 4'd1;
   assign seg_dec   = SEG_ACTIVE_LOW ? LUT[count] : ~LUT[count];
`ifdef SEG_BLINK_EN
   logic blink;
   always_ff @(posedge sys_clk) begin
      if (sys_rst || state_nxt != PAUSE) blink <= 1'b0;
      else if (state == PAUSE && tick_in) blink <= ~blink;
   end
   assign shown = blink ? SEG_OFF : seg_dec;
`else
   assign shown = seg_dec;
`endif
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state      <= IDLE;
         count      <= 4'd0;
         running    <= 1'b0;
         wrap_pulse <= 1'b0;
         seg_sel    <= SEL_OFF;
         seg_led    <= SEG_OFF;
      end else begin
         state      <= state_nxt;
         count      <= count_nxt;
         running    <= state_nxt == RUN;
         wrap_pulse <= wrap_nxt;
         seg_sel    <= ~SEL_OFF;
         seg_led    <= shown;
      end
   end
endmodule

// File: tb/tb_seg_tick_counter.sv
// tb_seg_tick_counter: vector table on the default build, plus a MAX_VAL=9 non-inverted instance for wrap and polarity.
module tb_seg_tick_counter;
   logic       sys_clk = 0, sys_rst = 1;
   logic       tick_in = 0, start = 0, stop = 0, clr = 0, dir = 1;
   logic       tick9 = 0, start9 = 0, dir9 = 1;
   logic [5:0] seg_sel, seg_sel9;
   logic [7:0] seg_led, seg_led9;
   logic       wrap_pulse, running, wrap9, running9;
`ifdef SEG_BLINK_EN
   localparam bit BLINK = 1'b1;
`else
   localparam bit BLINK = 1'b0;
`endif
   seg_tick_counter dut (.sys_clk(sys_clk), .sys_rst(sys_rst), .tick_in(tick_in), .start(start), .stop(stop),
      .clr(clr), .dir(dir), .seg_sel(seg_sel), .seg_led(seg_led), .wrap_pulse(wrap_pulse), .running(running));
   seg_tick_counter #(.DIG_NUM(6), .MAX_VAL(4'd9), .SEG_ACTIVE_LOW(1'b0)) dut9 (.sys_clk(sys_clk), .sys_rst(sys_rst),
      .tick_in(tick9), .start(start9), .stop(1'b0), .clr(1'b0), .dir(dir9), .seg_sel(seg_sel9), .seg_led(seg_led9),
      .wrap_pulse(wrap9), .running(running9));
   always #5 sys_clk = ~sys_clk;
   typedef struct {
      bit r, s, p, c, t, d;
      logic [7:0] seg;
      logic [5:0] sel;
      logic w, run;
   } vec_t;
   typedef struct {
      int id;
      logic [7:0] seg;
      logic [5:0] sel;
      logic w, run;
   } exp_t;
   vec_t tbl[$];
   exp_t sb[$];
   int passed = 0, total = 0;
   task automatic add(bit r, s, p, c, t, d, logic [7:0] seg, logic [5:0] sel, logic w, logic run);
      tbl.push_back('{r, s, p, c, t, d, seg, sel, w, run});
   endtask
   task automatic chk(string n, int id, logic [7:0] a, logic [7:0] e);
      total++;
      if (a === e) passed++;
      else $display("FAIL %s step %0d: got %h, expected %h", n, id, a, e);
   endtask
   task automatic compare(bit nine);
      exp_t e = sb.pop_front();
      chk("seg_led", e.id, nine ? seg_led9 : seg_led, e.seg);
      chk("seg_sel", e.id, {2'b0, nine ? seg_sel9 : seg_sel}, {2'b0, e.sel});
      chk("wrap_pulse", e.id, {7'b0, nine ? wrap9 : wrap_pulse}, {7'b0, e.w});
      chk("running", e.id, {7'b0, nine ? running9 : running}, {7'b0, e.run});
   endtask
   task automatic step9(int id, bit r, s, t, d, logic [7:0] seg, logic [5:0] sel, logic w, logic run);
      sys_rst = r; start9 = s; tick9 = t; dir9 = d;
      sb.push_back('{id, seg, sel, w, run});
      @(posedge sys_clk);
      #1;
      compare(1'b1);
   endtask
   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1);
   end
   initial begin
      logic [7:0] cath [9];
      cath = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F};
      //   r  s  p  c  t  d   seg    sel   w  run
      add(1, 0, 0, 0, 0, 1, 8'hFF, 6'h3F, 0, 0);
      add(0, 0, 0, 0, 0, 1, 8'hC0, 6'h00, 0, 0);
      add(0, 1, 0, 0, 0, 1, 8'hC0, 6'h00, 0, 1);
      add(0, 0, 0, 0, 1, 1, 8'hC0, 6'h00, 0, 1);
      add(0, 0, 0, 0, 1, 1, 8'hF9, 6'h00, 0, 1);
      add(0, 0, 0, 0, 1, 1, 8'hA4, 6'h00, 0, 1);
      add(0, 0, 0, 0, 0, 1, 8'hB0, 6'h00, 0, 1);
      add(0, 0, 0, 0, 1, 0, 8'hB0, 6'h00, 0, 1);
      add(0, 0, 0, 0, 1, 0, 8'hA4, 6'h00, 0, 1);
      add(0, 0, 0, 0, 1, 0, 8'hF9, 6'h00, 0, 1);
      add(0, 0, 0, 0, 1, 0, 8'hC0, 6'h00, 1, 1);
      add(0, 0, 0, 0, 0, 0, 8'h8E, 6'h00, 0, 1);
      add(0, 0, 0, 0, 1, 1, 8'h8E, 6'h00, 1, 1);
      add(0, 0, 0, 0, 0, 1, 8'hC0, 6'h00, 0, 1);
      add(0, 0, 0, 0, 1, 1, 8'hC0, 6'h00, 0, 1);
      add(0, 0, 0, 0, 1, 1, 8'hF9, 6'h00, 0, 1);
      add(0, 0, 0, 0, 1, 1, 8'hA4, 6'h00, 0, 1);
      add(0, 0, 0, 0, 1, 1, 8'hB0, 6'h00, 0, 1);
      add(0, 0, 1, 0, 1, 1, 8'h99, 6'h00, 0, 0);
      add(0, 0, 0, 0, 1, 1, 8'h92, 6'h00, 0, 0);
      add(0, 0, 0, 0, 1, 1, BLINK ? 8'hFF : 8'h92, 6'h00, 0, 0);
      add(0, 0, 0, 0, 0, 1, 8'h92, 6'h00, 0, 0);
      add(0, 0, 1, 0, 0, 1, 8'h92, 6'h00, 0, 0);
      add(0, 1, 0, 0, 1, 1, 8'h92, 6'h00, 0, 1);
      add(0, 0, 0, 0, 1, 1, 8'h92, 6'h00, 0, 1);
      add(0, 0, 0, 0, 1, 1, 8'h82, 6'h00, 0, 1);
      add(0, 1, 0, 1, 1, 1, 8'hF8, 6'h00, 0, 0);
      add(0, 0, 0, 0, 0, 1, 8'hC0, 6'h00, 0, 0);
      add(0, 0, 0, 0, 1, 1, 8'hC0, 6'h00, 0, 0);
      add(0, 1, 0, 0, 0, 1, 8'hC0, 6'h00, 0, 1);
      add(0, 1, 0, 0, 1, 1, 8'hC0, 6'h00, 0, 1);
      add(0, 0, 0, 0, 1, 1, 8'hF9, 6'h00, 0, 1);
      add(1, 0, 0, 0, 1, 1, 8'hFF, 6'h3F, 0, 0);
      add(0, 0, 0, 0, 0, 1, 8'hC0, 6'h00, 0, 0);
      add(0, 0, 0, 0, 1, 0, 8'hC0, 6'h00, 0, 0);
      add(0, 1, 0, 0, 0, 0, 8'hC0, 6'h00, 0, 1);
      add(0, 0, 0, 1, 1, 0, 8'hC0, 6'h00, 0, 0);
      add(0, 0, 0, 0, 0, 0, 8'hC0, 6'h00, 0, 0);
      add(0, 0, 1, 0, 0, 1, 8'hC0, 6'h00, 0, 0);
      for (int i = 0; i < tbl.size(); i++) begin
         sys_rst = tbl[i].r; start = tbl[i].s; stop = tbl[i].p; clr = tbl[i].c; tick_in = tbl[i].t; dir = tbl[i].d;
         sb.push_back('{i, tbl[i].seg, tbl[i].sel, tbl[i].w, tbl[i].run});
         @(posedge sys_clk);
         #1;
         compare(1'b0);
      end
      {start, stop, clr, tick_in} = '0;
      // MAX_VAL=9, non-inverted outputs: 0 -> 9 down, 9 -> 0 up, and ten ticks per revolution
      step9(100, 1, 0, 0, 1, 8'h00, 6'h00, 0, 0);
      step9(101, 0, 1, 0, 1, 8'h3F, 6'h3F, 0, 1);
      step9(102, 0, 0, 1, 0, 8'h3F, 6'h3F, 1, 1);
      step9(103, 0, 0, 0, 0, 8'h6F, 6'h3F, 0, 1);
      step9(104, 0, 0, 1, 1, 8'h6F, 6'h3F, 1, 1);
      step9(105, 0, 0, 0, 1, 8'h3F, 6'h3F, 0, 1);
      for (int i = 1; i <= 9; i++) step9(105 + i, 0, 0, 1, 1, cath[i-1], 6'h3F, 0, 1);
      step9(115, 0, 0, 1, 1, 8'h6F, 6'h3F, 1, 1);
      step9(116, 0, 0, 0, 1, 8'h3F, 6'h3F, 0, 1);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
